lc3b_fetch_ctrl: RTL and testbench

Multi-cycle instruction-fetch sequencer for the LC-3b datapath. It drives the PC, MAR, MDR and IR load/select strobes and the memory read handshake, in the order MAR←PC, MDR←mem, IR←MDR, PC←PC+2. It then presents the fetched instruction to the execute controller through a valid/done handshake. It also supports halt/resume, a memory-response timeout with an error state, and a retired-fetch counter.

---
 rtl/lc3b_fetch_ctrl.sv | 106 ++++++++++
 tb/tb_lc3b_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3b_fetch_ctrl.sv
// LC-3b instruction-fetch sequencer.
// Steps MAR<-PC, MDR<-mem, IR<-MDR with PC<-PC+2, then holds the instruction
// for the execute controller until exec_done. Supports halt/resume, a
// memory-response timeout that parks the block in ERROR, and a retired-fetch
// counter.
module lc3b_fetch_ctrl #(
    parameter int MEM_TIMEOUT = 16,  // FETCH2 cycles allowed without mem_resp (>= 2)
    parameter int CNT_W       = 16   // fetch_count width
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mem_resp,
    input  logic             exec_done,
    input  logic             halt_req,
    input  logic             resume,
    output logic             load_mar,
    output logic             marmux_sel,
    output logic             mem_read,
    output logic             load_mdr,
    output logic             load_ir,
    output logic             load_pc,
    output logic [1:0]       pcmux_sel,
    output logic             instr_valid,
    output logic             halted,
    output logic             mem_error,
    output logic [CNT_W-1:0] fetch_count
);

    localparam int             TW      = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0]  TO_LAST = TW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH1 = 3'd0,
        S_FETCH2 = 3'd1,
        S_FETCH3 = 3'd2,
        S_ISSUE  = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [TW-1:0]     wait_q,  wait_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // State, wait counter and retired-fetch counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_FETCH1;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic. The wait counter is zero outside FETCH2, so every
    // entry into FETCH2 starts counting from 0; mem_resp beats the timeout.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        cnt_d   = cnt_q;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: begin
                if (mem_resp)
                    state_d = S_FETCH3;
                else if (wait_q == TO_LAST)
                    state_d = S_ERROR;
                else
                    wait_d = wait_q + 1'b1;
            end
            S_FETCH3: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (exec_done)
                    state_d = halt_req ? S_HALTED : S_FETCH1;
            end
            S_HALTED: begin
                if (resume)
                    state_d = S_FETCH1;
            end
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_FETCH1;
        endcase
    end

    // Output decode: pure state decode except load_mdr, which also needs mem_resp.
    always_comb begin
        load_mar    = (state_q == S_FETCH1);
        marmux_sel  = 1'b0;
        mem_read    = (state_q == S_FETCH2);
        load_mdr    = (state_q == S_FETCH2) && mem_resp;
        load_ir     = (state_q == S_FETCH3);
        load_pc     = (state_q == S_FETCH3);
        pcmux_sel   = 2'b00;
        instr_valid = (state_q == S_ISSUE);
        halted      = (state_q == S_HALTED);
        mem_error   = (state_q == S_ERROR);
        fetch_count = cnt_q;
    end

endmodule

// File: tb/tb_lc3b_fetch_ctrl.sv
// Directed bench for lc3b_fetch_ctrl (MEM_TIMEOUT=4, CNT_W=4).
// Outputs are sampled 1 time unit after the falling edge; inputs change on
// the falling edge.
module tb_lc3b_fetch_ctrl;

    logic       clk;
    logic       reset_n;
    logic       mem_resp, exec_done, halt_req, resume;
    logic       load_mar, marmux_sel, mem_read, load_mdr, load_ir, load_pc;
    logic [1:0] pcmux_sel;
    logic       instr_valid, halted, mem_error;
    logic [3:0] fetch_count;

    int vecs = 0;
    int errs = 0;

    // Observation vector, one bit per status/strobe output.
    localparam logic [7:0] MAR = 8'h80, RD = 8'h40, MDR = 8'h20, IR = 8'h10,
                           PC  = 8'h08, IV = 8'h04, HLT = 8'h02, ERR = 8'h01;
    logic [7:0] obs;
    assign obs = {load_mar, mem_read, load_mdr, load_ir, load_pc, instr_valid, halted, mem_error};

    lc3b_fetch_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .mem_resp(mem_resp), .exec_done(exec_done),
        .halt_req(halt_req), .resume(resume), .load_mar(load_mar), .marmux_sel(marmux_sel),
        .mem_read(mem_read), .load_mdr(load_mdr), .load_ir(load_ir), .load_pc(load_pc),
        .pcmux_sel(pcmux_sel), .instr_valid(instr_valid), .halted(halted),
        .mem_error(mem_error), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Hold reset for two cycles, release on a falling edge (state is FETCH1).
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; mem_resp = 1'b0; exec_done = 1'b0; halt_req = 1'b0; resume = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0; mem_resp = 1'b1; exec_done = 1'b1; halt_req = 1'b0; resume = 1'b0;
        #1;
        vecs++;
        if ((obs & ~MAR) !== 8'h00) begin
            errs++; $display("FAIL reset_strobes: got %b want %b (load_mar ignored)", obs & ~MAR, 8'h00);
        end
        vecs++;
        if (fetch_count !== 4'd0 || marmux_sel !== 1'b0 || pcmux_sel !== 2'b00) begin
            errs++; $display("FAIL reset_count: fetch_count=%0d marmux=%b pcmux=%b want 0/0/00",
                             fetch_count, marmux_sel, pcmux_sel);
        end
    endtask

    // Zero-wait memory, exec_done tied high: 4-cycle repeating pattern.
    task automatic test_back_to_back();
        logic [7:0] exp;
        do_reset();
        mem_resp = 1'b1; exec_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            case (k % 4)
                0:       exp = MAR;
                1:       exp = RD | MDR;
                2:       exp = IR | PC;
                default: exp = IV;
            endcase
            vecs++;
            if (obs !== exp) begin
                errs++; $display("FAIL b2b_strobes[%0d]: got %b want %b", k, obs, exp);
            end
            if (k % 4 == 3) begin
                vecs++;
                if (fetch_count !== 4'(k / 4 + 1)) begin
                    errs++; $display("FAIL b2b_count[%0d]: got %0d want %0d", k, fetch_count, k / 4 + 1);
                end
            end
            if (k % 4 == 0 || k % 4 == 2) begin
                vecs++;
                if (marmux_sel !== 1'b0 || pcmux_sel !== 2'b00) begin
                    errs++; $display("FAIL b2b_mux[%0d]: marmux=%b pcmux=%b want 0/00", k, marmux_sel, pcmux_sel);
                end
            end
        end
    endtask

    // mem_resp arrives on the 4th FETCH2 cycle: the timeout boundary, response wins.
    task automatic test_mem_delay();
        logic [7:0] exp;
        do_reset();
        #1;
        vecs++;
        if (obs !== MAR) begin errs++; $display("FAIL delay_f1: got %b want %b", obs, MAR); end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            mem_resp  = (k == 4);
            exec_done = (k == 6);
            #1;
            case (k)
                1, 2, 3: exp = RD;
                4:       exp = RD | MDR;
                5:       exp = IR | PC;
                default: exp = IV;
            endcase
            vecs++;
            if (obs !== exp) begin
                errs++; $display("FAIL delay[%0d]: got %b want %b", k, obs, exp);
            end
        end
        @(negedge clk);
        exec_done = 1'b0;
        #1;
        vecs++;
        if (obs !== MAR) begin errs++; $display("FAIL delay_refetch: got %b want %b", obs, MAR); end
    endtask

    // No response: ERROR after 4 FETCH2 cycles; only reset leaves it.
    task automatic test_timeout();
        do_reset();
        #1;
        vecs++;
        if (obs !== MAR) begin errs++; $display("FAIL to_f1: got %b want %b", obs, MAR); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); #1;
            vecs++;
            if (obs !== RD) begin errs++; $display("FAIL to_wait[%0d]: got %b want %b", k, obs, RD); end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            resume = 1'b1; exec_done = 1'b1; mem_resp = (k == 1);
            #1;
            vecs++;
            if (obs !== ERR) begin errs++; $display("FAIL to_error[%0d]: got %b want %b", k, obs, ERR); end
        end
        @(negedge clk);
        #2;
        reset_n = 1'b0; resume = 1'b0; exec_done = 1'b0; mem_resp = 1'b0;
        #1;
        vecs++;
        if (mem_error !== 1'b0 || mem_read !== 1'b0) begin
            errs++; $display("FAIL to_clear: mem_error=%b mem_read=%b want 0/0", mem_error, mem_read);
        end
    endtask

    // halt_req raised mid-fetch only takes effect at exec_done.
    task automatic test_halt();
        logic [7:0] exp;
        do_reset();
        mem_resp = 1'b1;
        #1;
        vecs++;
        if (obs !== MAR) begin errs++; $display("FAIL halt_f1: got %b want %b", obs, MAR); end
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            halt_req  = (k >= 1 && k <= 7);
            exec_done = (k == 4);
            resume    = (k == 7);
            #1;
            case (k)
                1:       exp = RD | MDR;
                2:       exp = IR | PC;
                3, 4:    exp = IV;
                5, 6, 7: exp = HLT;
                default: exp = MAR;
            endcase
            vecs++;
            if (obs !== exp) begin
                errs++; $display("FAIL halt[%0d]: got %b want %b", k, obs, exp);
            end
        end
        resume = 1'b0;
    endtask

    // Reset asserted between clock edges while in FETCH2.
    task automatic test_async_reset();
        do_reset();
        mem_resp = 1'b1; exec_done = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        vecs++;
        if (fetch_count !== 4'd1 || obs !== IV) begin
            errs++; $display("FAIL ar_first: count=%0d obs=%b want 1/%b", fetch_count, obs, IV);
        end
        @(negedge clk);
        mem_resp = 1'b0; exec_done = 1'b0;
        @(negedge clk); #1;
        vecs++;
        if (obs !== RD) begin errs++; $display("FAIL ar_f2: got %b want %b", obs, RD); end
        #2;
        reset_n = 1'b0;
        #1;
        vecs++;
        if (mem_read !== 1'b0 || fetch_count !== 4'd0) begin
            errs++; $display("FAIL ar_drop: mem_read=%b count=%0d want 0/0", mem_read, fetch_count);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        vecs++;
        if (obs !== MAR || fetch_count !== 4'd0) begin
            errs++; $display("FAIL ar_restart: obs=%b count=%0d want %b/0", obs, fetch_count, MAR);
        end
        @(negedge clk); #1;
        vecs++;
        if (obs !== RD) begin errs++; $display("FAIL ar_f2_again: got %b want %b", obs, RD); end
    endtask

    // 17 fetches with a 4-bit counter: 1..15, 0, 1.
    task automatic test_wrap();
        logic [4:0] n5;
        do_reset();
        mem_resp = 1'b1; exec_done = 1'b1;
        for (int n = 1; n <= 17; n++) begin
            repeat (3) @(negedge clk);
            #1;
            n5 = 5'(n);
            vecs++;
            if (instr_valid !== 1'b1 || fetch_count !== n5[3:0]) begin
                errs++; $display("FAIL wrap[%0d]: iv=%b count=%0d want 1/%0d", n, instr_valid, fetch_count, n5[3:0]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 1'b0; mem_resp = 1'b0; exec_done = 1'b0; halt_req = 1'b0; resume = 1'b0;
        test_reset();
        test_back_to_back();
        test_mem_delay();
        test_timeout();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
